// File: rtl/key_pkg.sv
// Shared constants, FSM state type and encode helpers for the key encoder.
package key_pkg;

  localparam int NUM_KEYS       = 4;
  localparam int CODE_W         = 2;
  localparam int DEF_DEBOUNCE   = 270000;
  localparam int DEF_CNT_W      = 24;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HELD = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    HELD = ST_HELD
  } key_state_e;

  // Highest set index wins; all-zero encodes to 0.
  function automatic logic [CODE_W-1:0] prio_enc(input logic [NUM_KEYS-1:0] d);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (d[i]) c = CODE_W'(i);
    return c;
  endfunction

  function automatic logic [CODE_W:0] popcnt(input logic [NUM_KEYS-1:0] d);
    logic [CODE_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      n = n + {{CODE_W{1'b0}}, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser plus a stable-sample debounce counter.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic btn_rst,
  input  logic key_n,
  output logic key_db
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             key_s;

  // Inverted after the chain so 1 means pressed.
  assign key_s = ~sync[1];

  always_ff @(posedge clk_in) begin
    if (btn_rst) begin
      sync   <= 2'b11;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      if (key_s == key_db) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        key_db <= ~key_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_encoder42.sv
// Debounced 4-key priority encoder: one valid strobe per press, code held until the next.
module key_encoder42
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk_in,
  input  logic                btn_rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [CODE_W-1:0]   code,
  output logic                valid,
  output logic                pressed,
  output logic                multi
);

  logic [NUM_KEYS-1:0] db;
  logic                any_c;
  logic                multi_c;
  logic [CODE_W-1:0]   enc_c;

  key_state_e        state, state_nx;
  logic [CODE_W-1:0] code_nx;
  logic              valid_nx;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_in (clk_in),
      .btn_rst(btn_rst),
      .key_n  (key_n[i]),
      .key_db (db[i])
    );
  end

  assign any_c   = |db;
  assign multi_c = popcnt(db) >= (CODE_W+1)'(2);
  assign enc_c   = prio_enc(db);

  // A new press is only accepted once every key has been released.
  always_comb begin
    state_nx = state;
    code_nx  = code;
    valid_nx = 1'b0;
    case (state)
      IDLE: if (any_c) begin
        code_nx  = enc_c;
        valid_nx = 1'b1;
        state_nx = HELD;
      end
      HELD: if (!any_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (btn_rst) begin
      state   <= IDLE;
      code    <= '0;
      valid   <= 1'b0;
      pressed <= 1'b0;
      multi   <= 1'b0;
    end else begin
      state   <= state_nx;
      code    <= code_nx;
      valid   <= valid_nx;
      pressed <= any_c;
      multi   <= multi_c;
    end
  end

endmodule

// File: tb/tb_key_encoder42.sv
// Bench for key_encoder42: directed plan scenarios plus random key activity vs a run-length model.
module tb_key_encoder42;

  localparam int D = 4;

  logic       clk_in = 1'b0;
  logic       btn_rst;
  logic [3:0] key_n;
  logic [1:0] code;
  logic       valid, pressed, multi;

  key_encoder42 #(.DEBOUNCE_CYCLES(D), .CNT_W(24)) dut (
    .clk_in (clk_in),
    .btn_rst(btn_rst),
    .key_n  (key_n),
    .code   (code),
    .valid  (valid),
    .pressed(pressed),
    .multi  (multi)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Model: raw samples delayed two edges; a key flips after D consecutive differing samples.
  logic [3:0] m_s1, m_s2, m_db;
  int         m_run [4];
  logic       m_armed;
  logic [1:0] e_code;
  logic       e_valid, e_pressed, e_multi;

  // Observed-event trackers for the directed checks.
  int         vcount, vlast, pcount, pfall;
  logic [1:0] vcode;
  logic       vmulti, vpressed;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] k);
    logic [3:0] cur;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_db = '0; m_armed = 1'b1;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      e_code = '0; e_valid = 0; e_pressed = 0; e_multi = 0;
    end else begin
      e_pressed = (m_db != 0);
      e_multi   = ($countones(m_db) >= 2);
      e_valid   = m_armed && (m_db != 0);
      if (e_valid) begin
        for (int i = 0; i < 4; i++) if (m_db[i]) e_code = 2'(i);
        m_armed = 1'b0;
      end else if (m_db == 0) begin
        m_armed = 1'b1;
      end
      cur = ~m_s2;
      for (int i = 0; i < 4; i++) begin
        if (cur[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_db[i]  = ~m_db[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
    end
  endtask

  // One clock: apply inputs, step the model alongside the edge, compare every output.
  task automatic cyc(input logic rst, input logic [3:0] k);
    btn_rst = rst;
    key_n   = k;
    @(posedge clk_in);
    #1;
    cyc_n++;
    model_step(rst, k);
    chk("valid",   valid,   e_valid);
    chk("code",    code,    e_code);
    chk("pressed", pressed, e_pressed);
    chk("multi",   multi,   e_multi);
    if (valid) begin
      vcount++; vlast = cyc_n; vcode = code; vmulti = multi; vpressed = pressed;
    end
    if (pressed) pcount++;
    else if (pfall < 0) pfall = cyc_n;
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, k);
  endtask

  task automatic clr_track();
    vcount = 0; vlast = -1; vcode = '0; vmulti = 0; vpressed = 0; pcount = 0; pfall = -1;
  endtask

  int n0;

  initial begin
    btn_rst = 1'b1;
    key_n   = 4'hF;
    clr_track();

    // Reset with all keys low: outputs pinned at 0 throughout.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b0000);
      chk("rst_code", code, 0);
      chk("rst_valid", valid, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_multi", multi, 0);
    end
    n0 = cyc_n;
    clr_track();
    hold(4'b0000, 10);
    chk("rst_first_evt_at", vlast, n0 + 7);
    chk("rst_evt_code", vcode, 3);
    hold(4'b1111, 12);

    // Single press of key 2, then release.
    n0 = cyc_n; clr_track();
    hold(4'b1011, 20);
    chk("single_vcount", vcount, 1);
    chk("single_at", vlast, n0 + 7);
    chk("single_code", vcode, 2);
    chk("single_pressed", vpressed, 1);
    n0 = cyc_n; clr_track();
    hold(4'b1111, 12);
    chk("release_fall_at", pfall, n0 + 7);
    chk("release_vcount", vcount, 0);

    // Bounce on key 1, shorter than the debounce window.
    clr_track();
    for (int r = 0; r < 4; r++) begin
      hold(4'b1101, 2);
      hold(4'b1111, 2);
    end
    hold(4'b1111, 8);
    chk("bounce_vcount", vcount, 0);
    chk("bounce_pressed", pcount, 0);
    clr_track();
    hold(4'b1101, 10);
    chk("bounce_hold_vcount", vcount, 1);
    chk("bounce_hold_code", vcode, 1);
    hold(4'b1111, 12);

    // Keys 3 and 0 together.
    clr_track();
    hold(4'b0110, 12);
    chk("prio_vcount", vcount, 1);
    chk("prio_code", vcode, 3);
    chk("prio_multi", vmulti, 1);
    chk("prio_pressed", vpressed, 1);
    hold(4'b1111, 12);

    // Held-set change: key 0, then add key 3 while held.
    clr_track();
    hold(4'b1110, 12);
    chk("held_first_code", vcode, 0);
    clr_track();
    hold(4'b0110, 12);
    chk("held_add_vcount", vcount, 0);
    chk("held_code_kept", code, 0);
    chk("held_multi", multi, 1);
    hold(4'b1111, 12);
    clr_track();
    hold(4'b0111, 12);
    chk("held_new_vcount", vcount, 1);
    chk("held_new_code", vcode, 3);
    hold(4'b1111, 12);

    // Reset while HELD on key 1 with the key kept down.
    hold(4'b1101, 12);
    cyc(1'b1, 4'b1101);
    chk("midrst_code", code, 0);
    chk("midrst_pressed", pressed, 0);
    chk("midrst_valid", valid, 0);
    n0 = cyc_n; clr_track();
    hold(4'b1101, 12);
    chk("midrst_evt_at", vlast, n0 + 7);
    chk("midrst_code_after", vcode, 1);
    hold(4'b1111, 12);

    // Random key activity with random hold lengths and occasional resets.
    for (int s = 0; s < 400; s++) begin
      logic [3:0] k;
      int         len;
      k   = 4'($urandom);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) cyc(1'b1, k);
      hold(k, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
